// File: rtl/grf_pkg.sv
// grf_pkg: shared select codes, register names and types for the write-back stage
package grf_pkg;
    typedef logic [4:0] reg_addr_t;
    typedef logic [31:0] word_t;
    localparam logic [1:0] A3_SEL_RT = 2'd0;
    localparam logic [1:0] A3_SEL_RD = 2'd1;
    localparam logic [1:0] A3_SEL_RA = 2'd2;
    localparam logic [1:0] WD_SEL_ALU = 2'd0;
    localparam logic [1:0] WD_SEL_DM = 2'd1;
    localparam logic [1:0] WD_SEL_PC4 = 2'd2;
    localparam reg_addr_t REG_ZERO = 5'd0;
    localparam reg_addr_t REG_RA = 5'd31;
endpackage

// File: rtl/grf_writeback_if.sv
// grf_writeback_if: control/data inputs, read ports and write log of the write-back stage
interface grf_writeback_if;
    import grf_pkg::*;
    logic grf_we;
    logic [1:0] a3_sel;
    logic [1:0] wd_sel;
    reg_addr_t rt;
    reg_addr_t rd;
    word_t alu_res;
    word_t dm_data;
    word_t pc;
    reg_addr_t a1;
    reg_addr_t a2;
    word_t rd1;
    word_t rd2;
    logic wb_valid;
    word_t wb_pc;
    reg_addr_t wb_addr;
    word_t wb_data;
    modport master (
        output grf_we, a3_sel, wd_sel, rt, rd, alu_res, dm_data, pc, a1, a2,
        input rd1, rd2, wb_valid, wb_pc, wb_addr, wb_data
    );
    modport slave (
        input grf_we, a3_sel, wd_sel, rt, rd, alu_res, dm_data, pc, a1, a2,
        output rd1, rd2, wb_valid, wb_pc, wb_addr, wb_data
    );
endinterface

// File: rtl/grf_writeback_core.sv
// grf_core: 32x32 register array with $0 masking and two optionally bypassed read ports
module grf_core
    import grf_pkg::*;
#(
    parameter bit BYPASS = 1'b1
) (
    input logic clk,
    input logic reset,
    input logic we,
    input reg_addr_t wa,
    input word_t wd,
    input reg_addr_t a1,
    input reg_addr_t a2,
    output word_t rd1,
    output word_t rd2
);
    word_t regs [32];
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (we && wa != REG_ZERO) begin
            regs[wa] <= wd;
        end
    end
    always_comb begin
        rd1 = (a1 == REG_ZERO) ? '0 : (BYPASS && we && a1 == wa) ? wd : regs[a1];
        rd2 = (a2 == REG_ZERO) ? '0 : (BYPASS && we && a2 == wa) ? wd : regs[a2];
    end
endmodule

// File: rtl/grf_writeback.sv
// grf_writeback: destination/data select decode, write qualification and registered write log
module grf_writeback
    import grf_pkg::*;
#(
    parameter bit BYPASS = 1'b1,
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input logic clk,
    input logic reset,
    grf_writeback_if.slave bus
);
    reg_addr_t a3;
    word_t wd;
    logic wr_en;
    always_comb begin
        a3 = (bus.a3_sel == A3_SEL_RT) ? bus.rt : (bus.a3_sel == A3_SEL_RD) ? bus.rd : REG_RA;
        wd = (bus.wd_sel == WD_SEL_ALU) ? bus.alu_res : (bus.wd_sel == WD_SEL_DM) ? bus.dm_data : bus.pc + 32'd4;
        wr_en = bus.grf_we && bus.a3_sel != 2'd3 && bus.wd_sel != 2'd3 && a3 != REG_ZERO;
    end
    grf_core #(.BYPASS(BYPASS)) u_core (
        .clk(clk),
        .reset(reset),
        .we(wr_en),
        .wa(a3),
        .wd(wd),
        .a1(bus.a1),
        .a2(bus.a2),
        .rd1(bus.rd1),
        .rd2(bus.rd2)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.wb_valid <= 1'b0;
            bus.wb_pc <= RESET_PC;
            bus.wb_addr <= REG_ZERO;
            bus.wb_data <= '0;
        end else begin
            bus.wb_valid <= wr_en;
            if (wr_en) begin
                bus.wb_pc <= bus.pc;
                bus.wb_addr <= a3;
                bus.wb_data <= wd;
            end
        end
    end
endmodule

// File: tb/tb_grf_writeback.sv
// tb_grf_writeback: randomized and directed scoreboard bench driving a bypassed and a non-bypassed instance
module tb_grf_writeback;
    import grf_pkg::*;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic grf_we = 1'b0;
    logic [1:0] a3_sel = '0, wd_sel = '0;
    logic [4:0] rt = '0, rd = '0, a1 = '0, a2 = '0;
    logic [31:0] alu_res = '0, dm_data = '0, pc = '0;
    int checks = 0, errors = 0;
    bit model_ok = 1'b0;
    logic [31:0] m_regs [32];
    typedef struct {logic [31:0] pc; logic [4:0] addr; logic [31:0] data;} log_t;
    log_t q[$];
    always #5 clk = ~clk;
    grf_writeback_if ib ();
    grf_writeback_if nb ();
    assign ib.grf_we = grf_we;   assign nb.grf_we = grf_we;
    assign ib.a3_sel = a3_sel;   assign nb.a3_sel = a3_sel;
    assign ib.wd_sel = wd_sel;   assign nb.wd_sel = wd_sel;
    assign ib.rt = rt;           assign nb.rt = rt;
    assign ib.rd = rd;           assign nb.rd = rd;
    assign ib.alu_res = alu_res; assign nb.alu_res = alu_res;
    assign ib.dm_data = dm_data; assign nb.dm_data = dm_data;
    assign ib.pc = pc;           assign nb.pc = pc;
    assign ib.a1 = a1;           assign nb.a1 = a1;
    assign ib.a2 = a2;           assign nb.a2 = a2;
    grf_writeback #(.BYPASS(1'b1), .RESET_PC(32'h0000_3000)) u_byp (.clk(clk), .reset(reset), .bus(ib));
    grf_writeback #(.BYPASS(1'b0), .RESET_PC(32'h0000_3000)) u_nob (.clk(clk), .reset(reset), .bus(nb));

    function automatic logic [4:0] m_a3();
        logic [4:0] t [3];
        t = '{rt, rd, 5'd31};
        return (a3_sel == 2'd3) ? 5'd0 : t[a3_sel];
    endfunction
    function automatic logic [31:0] m_wd();
        logic [31:0] t [3];
        t = '{alu_res, dm_data, pc + 32'd4};
        return (wd_sel == 2'd3) ? 32'd0 : t[wd_sel];
    endfunction
    function automatic bit m_wen();
        return grf_we && a3_sel != 2'd3 && wd_sel != 2'd3 && m_a3() != 5'd0;
    endfunction
    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 32'd0;
        if (byp && m_wen() && a == m_a3()) return m_wd();
        return m_regs[a];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        if (model_ok) begin
            check("rd1_bypass", ib.rd1, exp_rd(a1, 1'b1));
            check("rd2_bypass", ib.rd2, exp_rd(a2, 1'b1));
            check("rd1_nobypass", nb.rd1, exp_rd(a1, 1'b0));
            check("rd2_nobypass", nb.rd2, exp_rd(a2, 1'b0));
        end
        @(posedge clk);
        if (reset) begin
            foreach (m_regs[i]) m_regs[i] = 32'd0;
            model_ok = 1'b1;
        end else if (m_wen()) begin
            m_regs[m_a3()] = m_wd();
            q.push_back('{pc: pc, addr: m_a3(), data: m_wd()});
        end
        #1;
    endtask

    task automatic rnd();
        int k;
        reset = 1'b0;
        grf_we = ($urandom_range(0, 3) != 0);
        a3_sel = 2'($urandom_range(0, 3));
        wd_sel = 2'($urandom_range(0, 3));
        rt = 5'($urandom);
        rd = 5'($urandom);
        alu_res = $urandom;
        dm_data = $urandom;
        pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
        k = $urandom_range(0, 3);
        a1 = (k == 0) ? rt : (k == 1) ? rd : (k == 2) ? 5'd31 : 5'($urandom);
        a2 = ($urandom_range(0, 1) == 0) ? a1 : 5'($urandom);
    endtask

    task automatic check_log_idle(input string name);
        check({name, "_valid_byp"}, 32'(ib.wb_valid), 32'd0);
        check({name, "_valid_nob"}, 32'(nb.wb_valid), 32'd0);
    endtask

    task automatic sweep();
        grf_we = 1'b0;
        for (int i = 0; i < 32; i++) begin
            a1 = 5'(i);
            a2 = 5'(31 - i);
            cycle();
        end
    endtask

    always @(negedge clk) begin
        if (ib.wb_valid === 1'b1 || nb.wb_valid === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL log_spurious: got wb_valid byp=%b nob=%b expected no write", ib.wb_valid, nb.wb_valid);
            end else begin
                log_t e;
                e = q.pop_front();
                check("log_valid_byp", 32'(ib.wb_valid), 32'd1);
                check("log_valid_nob", 32'(nb.wb_valid), 32'd1);
                check("log_pc", ib.wb_pc, e.pc);
                check("log_addr", 32'(ib.wb_addr), 32'(e.addr));
                check("log_data", ib.wb_data, e.data);
                check("log_pc_nob", nb.wb_pc, e.pc);
                check("log_addr_nob", 32'(nb.wb_addr), 32'(e.addr));
                check("log_data_nob", nb.wb_data, e.data);
            end
        end
    end

    initial begin
        logic [31:0] v;
        foreach (m_regs[i]) m_regs[i] = 32'd0;
        reset = 1'b1;
        cycle();
        cycle();
        for (int i = 0; i < 20; i++) begin rnd(); cycle(); end
        for (int i = 0; i < 2; i++) begin rnd(); reset = 1'b1; grf_we = 1'b1; cycle(); end
        reset = 1'b0;
        grf_we = 1'b0;
        check_log_idle("reset");
        check("reset_wb_pc", ib.wb_pc, 32'h0000_3000);
        check("reset_wb_addr", 32'(ib.wb_addr), 32'd0);
        check("reset_wb_data", ib.wb_data, 32'd0);
        sweep();
        rnd(); grf_we = 1'b1; a3_sel = 2'd1; rd = 5'd8; wd_sel = 2'd0; alu_res = 32'h1234_5678; pc = 32'h0000_3040;
        cycle();
        grf_we = 1'b0; a1 = 5'd8;
        #1;
        check("alu_rd_rd1", nb.rd1, 32'h1234_5678);
        check("alu_rd_wb_valid", 32'(ib.wb_valid), 32'd1);
        check("alu_rd_wb_addr", 32'(ib.wb_addr), 32'd8);
        check("alu_rd_wb_pc", ib.wb_pc, 32'h0000_3040);
        cycle();
        rnd(); grf_we = 1'b1; a3_sel = 2'd2; wd_sel = 2'd2; pc = 32'h0000_3010;
        cycle();
        grf_we = 1'b0; a1 = 5'd31;
        #1;
        check("jal_link", nb.rd1, 32'h0000_3014);
        grf_we = 1'b1; a3_sel = 2'd2; wd_sel = 2'd2; pc = 32'hFFFF_FFFC;
        cycle();
        grf_we = 1'b0; a1 = 5'd31;
        #1;
        check("jal_wrap", nb.rd1, 32'd0);
        rnd(); grf_we = 1'b1; a3_sel = 2'd0; rt = 5'd0; wd_sel = 2'd0; alu_res = 32'hDEAD_BEEF; a1 = 5'd0;
        cycle();
        check_log_idle("zero_dest");
        a3_sel = 2'd3; rt = 5'd8; rd = 5'd8;
        cycle();
        check_log_idle("a3_reserved");
        a3_sel = 2'd1; wd_sel = 2'd3;
        cycle();
        check_log_idle("wd_reserved");
        grf_we = 1'b0; a1 = 5'd0; a2 = 5'd8;
        #1;
        check("zero_reg", nb.rd1, 32'd0);
        check("reserved_no_change", nb.rd2, 32'h1234_5678);
        rnd(); grf_we = 1'b1; a3_sel = 2'd0; rt = 5'd5; wd_sel = 2'd1; dm_data = 32'h1111_1111;
        cycle();
        dm_data = 32'hA5A5_A5A5; a1 = 5'd5; a2 = 5'd5;
        #1;
        check("bypass_rd1", ib.rd1, 32'hA5A5_A5A5);
        check("bypass_rd2", ib.rd2, 32'hA5A5_A5A5);
        check("nobypass_rd1_old", nb.rd1, 32'h1111_1111);
        check("nobypass_rd2_old", nb.rd2, 32'h1111_1111);
        cycle();
        grf_we = 1'b0;
        #1;
        check("nobypass_rd1_new", nb.rd1, 32'hA5A5_A5A5);
        rnd(); grf_we = 1'b1; a3_sel = 2'd1; rd = 5'd9; wd_sel = 2'd0; alu_res = 32'h0BAD_F00D;
        cycle();
        rnd(); reset = 1'b1; grf_we = 1'b1; a3_sel = 2'd1; rd = 5'd9; wd_sel = 2'd0; alu_res = 32'hCAFE_0009;
        cycle();
        reset = 1'b0; grf_we = 1'b0; a1 = 5'd9; a2 = 5'd9;
        #1;
        check("reset_collision_byp", ib.rd1, 32'd0);
        check("reset_collision_nob", nb.rd2, 32'd0);
        check_log_idle("reset_collision");
        for (int i = 0; i < 400; i++) begin
            rnd();
            if ($urandom_range(0, 49) == 0) reset = 1'b1;
            cycle();
        end
        reset = 1'b0;
        sweep();
        v = 32'(q.size());
        check("log_queue_drained", v, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/grf_writeback.md
# grf_writeback

Write-back stage and general register file for the MIPS datapath. Consumes the two 2-bit select codes produced by the mux-control decoder, the candidate destination fields and the candidate write data. It resolves the effective destination register and write value, commits them to a 32×32 register array on the clock edge, and serves two combinational read ports with optional same-cycle write-through bypass. A registered write-log port exposes every committed write for the trace checker.

## Interface
Parameters:
- BYPASS, 1, 1 = read ports return same-cycle write data on address match; 0 = read pre-edge array contents
- RESET_PC, 32'h0000_3000, value driven on wb_pc while reset

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; priority over every other input
- grf_we  in  1  register-write request from control
- a3_sel  in  2  destination select: 0 = rt, 1 = rd, 2 = $31, 3 = reserved
- wd_sel  in  2  data select: 0 = ALU result, 1 = DM read data, 2 = PC+4, 3 = reserved
- rt  in  5  instr[20:16]
- rd  in  5  instr[15:11]
- alu_res  in  32  ALU output
- dm_data  in  32  data-memory read data
- pc  in  32  PC of the instruction being written back
- a1  in  5  read address 1 (rs)
- a2  in  5  read address 2 (rt)
- rd1  out  32  read data 1
- rd2  out  32  read data 2
- wb_valid  out  1  registered: a write committed on the previous edge
- wb_pc  out  32  registered PC of that write
- wb_addr  out  5  registered destination of that write
- wb_data  out  32  registered data of that write

## Operation
- Destination: a3 = rt / rd / 5'd31 for a3_sel 0 / 1 / 2.
- Data: wd = alu_res / dm_data / pc+4 for wd_sel 0 / 1 / 2. pc+4 is a 32-bit add; wraps modulo 2^32.
- Effective write: wr_en = grf_we & (a3_sel != 3) & (wd_sel != 3) & (a3 != 0). Reserved codes suppress the write silently.
- Commit: on a rising edge with wr_en=1 and reset=0, regs[a3] <= wd.
- $0 is never written. Reads of address 0 always return 0.
- Read port k (a = a1 or a2):
  - rdk = 0 if a == 0.
  - Otherwise, if BYPASS=1 & wr_en & a == a3, rdk = wd.
  - Otherwise rdk = regs[a].
- Both ports may target the same address, and may match the write address simultaneously; each resolves independently.
- Write log: each edge, wb_valid <= wr_en. When wr_en=1, wb_pc/wb_addr/wb_data <= pc/a3/wd. When wr_en=0, those three fields hold their values.

## Timing
- Reset (edge with reset=1):
  - All 32 registers <= 0.
  - wb_valid <= 0, wb_pc <= RESET_PC, wb_addr <= 0, wb_data <= 0.
  - Any concurrent write is discarded.
- Reset asserted mid-stream: the write presented in that cycle is lost. The first post-reset write commits on the first edge with reset=0.
- Write latency: one edge. With BYPASS=0, a read of the written register shows the new value in the cycle after that edge. With BYPASS=1, it shows the new value in the same cycle (combinational through wd).
- Read ports are purely combinational from a1/a2, the select inputs, the data inputs and the array. There is no read latency.
- Write-log latency: one cycle after commit. wb_* is stable for the whole following cycle.
- Back-to-back writes to the same register: the last edge wins. The log shows each write in turn.

## Structure
- Package grf_pkg holds:
  - A3_SEL_RT=0, A3_SEL_RD=1, A3_SEL_RA=2
  - WD_SEL_ALU=0, WD_SEL_DM=1, WD_SEL_PC4=2
  - REG_ZERO=5'd0, REG_RA=5'd31
  - Two typedefs: reg_addr_t (5 bits) and word_t (32 bits)
- Sub-module grf_core: the 32×32 array, $0 masking and the two bypassed read ports. Its inputs are a resolved write enable, write address and write data.
- The top level does select decoding, wr_en qualification and the write-log register.

## Test plan
- Reset: hold reset 2 cycles after random writes. Required: every rd1/rd2 read = 0, wb_valid=0, wb_pc=32'h3000.
- ALU to rd: grf_we=1, a3_sel=1, rd=8, wd_sel=0, alu_res=32'h1234_5678. Required: after the edge, a1=8 gives rd1=32'h1234_5678. Next cycle: wb_valid=1, wb_addr=8, wb_pc=pc.
- jal link: a3_sel=2, wd_sel=2, pc=32'h0000_3010. Required: $31 = 32'h0000_3014. With pc=32'hFFFF_FFFC, $31 = 0 (wrap).
- $0 and reserved codes: a write to rt=0 with data 32'hDEAD_BEEF, then separate writes with a3_sel=3 and with wd_sel=3. Required: $0 stays 0, no register changes, wb_valid=0.
- Bypass: BYPASS=1, write $5 <= 32'hA5A5_A5A5 with a1=a2=5 in the same cycle. Required: rd1=rd2=32'hA5A5_A5A5 before the edge. With BYPASS=0, both show the old value until after the edge.
- Reset collision: reset=1 together with a write to $9. Required: $9=0 after the edge and wb_valid=0.
